// File: rtl/xg_mem_arbiter_pkg.sv
// XenonGecko shared types: arbiter states, burst length, memory address.
package xg_mem_arbiter_pkg;

    localparam int BURST_LEN = 4;
    localparam int ADDR_W    = 24;

    localparam logic [1:0] LAST_OFFSET = 2'(BURST_LEN - 1);

    typedef logic [ADDR_W-1:0] xg_addr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_VID,
        ST_CPU,
        ST_ERR
    } xg_arb_state_t;

endpackage

// File: rtl/xg_mem_arbiter_if.sv
// Bus bundle between xgmm requesters, the arbiter and the SDRAM controller.
interface xg_mem_arbiter_if;
    import xg_mem_arbiter_pkg::*;

    logic        vid_req;
    xg_addr_t    vid_addr;
    logic        vid_ready;
    logic [1:0]  vid_offset;
    logic [15:0] vid_data;
    logic        vid_done;

    logic        cpu_req;
    logic        cpu_wren;
    xg_addr_t    cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ready;
    logic [1:0]  cpu_offset;
    logic [15:0] cpu_rdata;
    logic        cpu_done;

    logic        mem_req;
    logic        mem_wren;
    xg_addr_t    mem_addr;
    logic        mem_ready;
    logic [1:0]  mem_offset;
    logic [15:0] from_mem;
    logic [15:0] to_mem;
    logic        mem_error;

    // slave: the arbiter's view of the bundle
    modport slave (
        input  vid_req, vid_addr,
        output vid_ready, vid_offset, vid_data, vid_done,
        input  cpu_req, cpu_wren, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_offset, cpu_rdata, cpu_done,
        output mem_req, mem_wren, mem_addr, to_mem, mem_error,
        input  mem_ready, mem_offset, from_mem
    );

    modport master (
        output vid_req, vid_addr,
        input  vid_ready, vid_offset, vid_data, vid_done,
        output cpu_req, cpu_wren, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_offset, cpu_rdata, cpu_done,
        input  mem_req, mem_wren, mem_addr, to_mem, mem_error,
        output mem_ready, mem_offset, from_mem
    );

endinterface

// File: rtl/xg_mem_arbiter.sv
// Video/CPU burst arbiter in front of the SDRAM controller, with
// CPU anti-starvation and a first-word timeout.
module xg_mem_arbiter
    import xg_mem_arbiter_pkg::*;
#(
    parameter int unsigned CPU_STARVE_LIMIT = 3,
    parameter int unsigned TIMEOUT_CYCLES   = 255
) (
    input  logic              clk_sys,
    input  logic              rst,
    xg_mem_arbiter_if.slave   bus
);

    localparam logic [1:0] STARVE_LIM = 2'(CPU_STARVE_LIMIT);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT_CYCLES - 1);

    xg_arb_state_t r_state;
    xg_arb_state_t w_next;

    xg_addr_t    r_addr;
    logic        r_wren;
    logic        r_cpu;
    logic        r_seen;
    logic        r_err;
    logic [1:0]  r_starve;
    logic [7:0]  r_tmo;

    logic w_vid;
    logic w_cpu;
    logic w_busy;
    logic w_last;
    logic w_timeout;
    logic w_gnt_vid;
    logic w_gnt_cpu;

    assign w_vid  = (r_state == ST_VID);
    assign w_cpu  = (r_state == ST_CPU);
    assign w_busy = w_vid | w_cpu;
    assign w_last = bus.mem_ready
                  & (bus.mem_offset == LAST_OFFSET);

    assign w_timeout = w_busy & ~r_seen & ~bus.mem_ready
                     & (r_tmo == TMO_LAST);

    always_comb begin
        w_next    = r_state;
        w_gnt_vid = 1'b0;
        w_gnt_cpu = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.cpu_req &&
                    (!bus.vid_req || r_starve >= STARVE_LIM)) begin
                    w_next    = ST_CPU;
                    w_gnt_cpu = 1'b1;
                end else if (bus.vid_req) begin
                    w_next    = ST_VID;
                    w_gnt_vid = 1'b1;
                end
            end
            ST_VID, ST_CPU: begin
                if (w_last) begin
                    w_next = ST_IDLE;
                end else if (w_timeout) begin
                    w_next = ST_ERR;
                end
            end
            ST_ERR: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_wren   <= 1'b0;
            r_cpu    <= 1'b0;
            r_seen   <= 1'b0;
            r_err    <= 1'b0;
            r_starve <= '0;
            r_tmo    <= '0;
        end else begin
            r_state <= w_next;
            if (w_gnt_vid) begin
                r_addr <= bus.vid_addr;
                r_wren <= 1'b0;
            end else if (w_gnt_cpu) begin
                r_addr <= bus.cpu_addr;
                r_wren <= bus.cpu_wren;
            end
            if (w_gnt_vid || w_gnt_cpu) begin
                r_cpu  <= w_gnt_cpu;
                r_seen <= 1'b0;
                r_tmo  <= '0;
            end else if (w_busy) begin
                if (bus.mem_ready) begin
                    r_seen <= 1'b1;
                end else if (!r_seen) begin
                    r_tmo <= r_tmo + 8'd1;
                end
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            // CPU wins once video has been granted STARVE_LIM times in a row
            if (w_gnt_cpu) begin
                r_starve <= '0;
            end else if (w_gnt_vid && bus.cpu_req) begin
                if (r_starve != 2'd3) begin
                    r_starve <= r_starve + 2'd1;
                end
            end else if (r_state == ST_IDLE && !bus.cpu_req) begin
                r_starve <= '0;
            end
        end
    end

    assign bus.mem_req   = w_busy;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wren  = w_cpu & r_wren;
    assign bus.to_mem    = (w_cpu && r_wren) ? bus.cpu_wdata : '0;
    assign bus.mem_error = r_err;

    assign bus.vid_ready  = w_vid & bus.mem_ready;
    assign bus.vid_offset = w_vid ? bus.mem_offset : '0;
    assign bus.vid_data   = w_vid ? bus.from_mem : '0;
    assign bus.vid_done   = (w_vid & w_last)
                          | ((r_state == ST_ERR) & ~r_cpu);

    assign bus.cpu_ready  = w_cpu & bus.mem_ready;
    assign bus.cpu_offset = w_cpu ? bus.mem_offset : '0;
    assign bus.cpu_rdata  = w_cpu ? bus.from_mem : '0;
    assign bus.cpu_done   = (w_cpu & w_last)
                          | ((r_state == ST_ERR) & r_cpu);

endmodule

// File: doc/xg_mem_arbiter.md
XG_MEM_ARBITER -- requirements
Module: xg_mem_arbiter

Interface
REQ-001 Parameter CPU_STARVE_LIMIT, default 3: number of consecutive video grants after which a waiting CPU request wins.
REQ-002 Parameter TIMEOUT_CYCLES, default 255: maximum cycles from mem_req assertion to the first mem_ready.
REQ-003 clk_sys  in  1  system/memory clock; the only clock.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 vid_req  in  1  video fetch request, held until vid_done.
REQ-006 vid_addr  in  24  video burst base address.
REQ-007 vid_ready  out  1  video read word valid.
REQ-008 vid_offset  out  2  word index of vid_data.
REQ-009 vid_data  out  16  video read word.
REQ-010 vid_done  out  1  one-cycle pulse on the last word of a video burst.
REQ-011 cpu_req  in  1  CPU request, held until cpu_done.
REQ-012 cpu_wren  in  1  CPU write (1) / read (0).
REQ-013 cpu_addr  in  24  CPU burst base address.
REQ-014 cpu_wdata  in  16  CPU write word for the index on cpu_offset.
REQ-015 cpu_ready  out  1  CPU word transferred.
REQ-016 cpu_offset  out  2  index of current CPU word.
REQ-017 cpu_rdata  out  16  CPU read word.
REQ-018 cpu_done  out  1  one-cycle pulse on the last CPU word.
REQ-019 mem_req, mem_wren  out  1 each  memory request and write strobe.
REQ-020 mem_addr  out  24  memory burst address; mem_ready, mem_offset (2), from_mem (16) in; to_mem (16) out.
REQ-021 mem_error  out  1  sticky timeout flag.

Function
REQ-022 States: IDLE, VID, CPU, ERR; one burst is 4 words, with mem_offset 0..3 each accompanied by mem_ready.
REQ-023 IDLE: if cpu_req and (not vid_req or starve_cnt >= CPU_STARVE_LIMIT), go to CPU; else if vid_req, go to VID; else stay in IDLE.
REQ-024 On a grant, latch the address and wren into registers on the same edge; mem_req, mem_addr and mem_wren become valid on the next cycle and hold until the burst ends.
REQ-025 VID: mem_wren=0, vid_ready=mem_ready, vid_offset=mem_offset, vid_data=from_mem, all combinational pass-through; cpu_ready=0.
REQ-026 CPU: cpu_ready=mem_ready, cpu_offset=mem_offset, cpu_rdata=from_mem, to_mem=cpu_wdata combinational; vid_ready=0.
REQ-027 A burst ends on mem_ready with mem_offset==3: pulse the matching done output in that cycle, drop mem_req at the next edge, and return to IDLE; the earliest re-grant is one cycle after the return.
REQ-028 starve_cnt (2-bit saturating): increment on a VID grant while cpu_req=1; clear on a CPU grant or when cpu_req=0 in IDLE.
REQ-029 Timeout counter (8-bit): clear on grant, increment each cycle in VID/CPU before the first mem_ready, and stop after the first mem_ready; when it reaches TIMEOUT_CYCLES, drop mem_req, set mem_error and go to ERR.
REQ-030 ERR: pulse the done output of the aborted requester once, then go to IDLE; mem_error stays set until rst.
REQ-031 A requester dropping its req mid-burst shall not abort the burst; the arbiter completes it to the memory.
REQ-032 to_mem=0 outside CPU write bursts; mem_ready in IDLE is ignored.

Reset
REQ-033 Reset shall force IDLE, with mem_req=0, mem_wren=0, mem_addr=0, to_mem=0, all ready/done=0, offsets=0, data outputs=0, starve_cnt=0, timeout=0, and mem_error=0.
REQ-034 Reset asserted mid-burst shall drop mem_req immediately (asynchronously); the next request after release shall be served from IDLE normally.

Structure
REQ-035 The shared XenonGecko package shall hold the state enum, BURST_LEN=4 and the 24-bit memory address type.
REQ-036 The block shall be a single module with no sub-modules; it sits between xgmm and the SDRAM controller.

Verification
REQ-037 vid_req alone at addr 0x000100, memory returning 0xA0..0xA3 -> mem_addr=0x000100, vid_data in sequence with offsets 0..3, one vid_done, cpu_ready never asserted.
REQ-038 cpu_req write at 0x123456 with wdata=0x1111+offset -> mem_wren=1 and to_mem 0x1111..0x1114 on offsets 0..3, then cpu_done.
REQ-039 vid_req and cpu_req held continuously -> grant order V,V,V,C,V,V,V,C.
REQ-040 mem_ready never asserted -> mem_req drops after 255 cycles, mem_error=1, the requester's done pulses once, and the next request is served.
REQ-041 rst asserted at offset 1 of a burst -> mem_req=0 within the same cycle and all outputs at reset values; a vid_req after release completes.
REQ-042 cpu_req dropped at offset 2 -> burst completes through offset 3 and cpu_done pulses.
